mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous data RAM between the processor core (microcode-driven load/store path) and the host loader, which preloads programs and reads back results.
- Grants at most one access per cycle. Returns read data with fixed 1-cycle latency. Bounds the length of consecutive grants so neither side starves.
- Sits between the core memory interface, the host loader and the RAM macro.

Parameters:
- ADDR_W, 8, address width of the RAM.
- DATA_W, 8, data width of the RAM.
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is requesting (range 1..15).
- HOST_FIRST, 1, tie-break owner after reset (1 = host wins the first contested cycle).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- core_req  in  1  core access request; level, held until granted
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core access accepted this cycle
- core_rvalid  out  1  core read data valid
- core_rdata  out  DATA_W  core read data
- host_req  in  1  host access request; level, held until granted
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_lock  in  1  host requests exclusive ownership (program load)
- host_gnt  out  1  host access accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values:
  - all outputs 0
  - last_owner = HOST if HOST_FIRST else CORE
  - burst_cnt = 0
  - lock_state = UNLOCKED
- Grant rules:
  - Grant is combinational from req and registered state.
  - Exactly one of core_gnt/host_gnt is high in any cycle, or neither.
  - mem_* are driven from the granted requester in the same cycle; all zero when neither is granted.
- Arbitration order:
  1. lock_state = LOCKED: host only; core_gnt = 0.
  2. Single requester: that requester wins.
  3. Both requesting, burst_cnt < MAX_BURST: last_owner wins again.
  4. Both requesting, burst_cnt = MAX_BURST: the other side wins.
- burst_cnt:
  - Increments, saturating at MAX_BURST, on a grant to last_owner while the other side is requesting.
  - Resets to 1 when ownership changes; resets to 0 when the other side is idle.
- Lock FSM (UNLOCKED, LOCKED):
  - UNLOCKED -> LOCKED on host_gnt with host_lock = 1.
  - LOCKED -> UNLOCKED the cycle after host_lock falls.
  - While LOCKED, burst limiting is disabled.
- Read return:
  - A granted read registers a 1-bit return tag.
  - The next cycle, the tagged side's rvalid = 1 and its rdata = mem_rdata.
  - The other side's rdata holds its last value.
  - Writes produce no rvalid.
- Back-to-back reads from either side are fully pipelined: one per cycle, latency 1.
- Simultaneous read return and new grant is legal; the tag pipeline is independent of grant.
- Reset mid-read: the pending rvalid is dropped; there is no rvalid after reset release.
- Address/data are not checked; wrap-around is the RAM's concern.

Optional Feature:
- Macro: ARB_STALL_STATS_EN.
- With the macro defined, the block adds:
  - output core_stall_cnt [15:0]: counts cycles with core_req = 1 and core_gnt = 0; saturates at 16'hFFFF.
  - input stats_clr: synchronous clear.
  - Both reset to 0.
- Without the macro, these ports and the counter do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg:
  - owner_t enum: OWN_CORE, OWN_HOST.
  - lock_t enum: UNLOCKED, LOCKED.
  - Constant BURST_W = 4.
- One natural sub-module, arb_pick: combinational winner select from reqs, last_owner, burst_cnt and lock_state.
- Registers stay in mem_port_arbiter.

Test Plan:
- Core-only read of addr 8'h10 (RAM holds 8'hA5) -> core_gnt same cycle; core_rvalid = 1 with core_rdata = 8'hA5 next cycle; host_rvalid = 0.
- Both request continuously after reset, MAX_BURST = 4, HOST_FIRST = 1 -> grants H,H,H,H,C,C,C,C,H...; never two grants in one cycle.
- Host lock: host_lock = 1 and writes 16 bytes while core_req = 1 -> 16 consecutive host_gnt, core_gnt = 0 throughout; core granted the 2nd cycle after host_lock drops.
- Interleaved reads: core reads 8'h01 then host reads 8'h02 on consecutive cycles -> core_rvalid then host_rvalid on consecutive cycles with matching data.
- Reset asserted the cycle after a granted read -> no rvalid is ever seen; all outputs are 0 asynchronously.
- ARB_STALL_STATS_EN: core blocked for 10 cycles by lock -> core_stall_cnt = 10; stats_clr -> 0 next cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the core/host RAM port arbiter.
package mem_arb_pkg;

    localparam int BURST_W = 4;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_t;

    // Burst counter increment that sticks at the configured ceiling.
    function automatic logic [BURST_W-1:0] burst_sat_inc(
        input logic [BURST_W-1:0] cnt,
        input logic [BURST_W-1:0] max_cnt
    );
        logic [BURST_W-1:0] res;
        if (cnt >= max_cnt) begin
            res = max_cnt;
        end else begin
            res = cnt + {{(BURST_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select for the RAM port: lock first, then single
// requester, then last-owner stickiness bounded by the burst counter.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               core_req,
    input  logic               host_req,
    input  owner_t             last_owner,
    input  logic [BURST_W-1:0] burst_cnt,
    input  lock_t              lock_state,
    output logic               core_win,
    output logic               host_win
);

    localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

    logic keep_owner_s;

    assign keep_owner_s = (burst_cnt < MAX_B);

    // Winner select; at most one of core_win/host_win is ever set.
    always_comb begin
        core_win = 1'b0;
        host_win = 1'b0;
        if (lock_state == LOCKED) begin
            host_win = host_req;
        end else if (core_req && host_req) begin
            if ((last_owner == OWN_HOST) == keep_owner_s) begin
                host_win = 1'b1;
            end else begin
                core_win = 1'b1;
            end
        end else begin
            core_win = core_req;
            host_win = host_req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between the core load/store path and the host loader.
// Optional core stall counter is built when ARB_STALL_STATS_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int MAX_BURST  = 4,
    parameter int HOST_FIRST = 1
) (
`ifdef ARB_STALL_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       core_stall_cnt,
`endif
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [BURST_W-1:0] MAX_B     = BURST_W'(MAX_BURST);
    localparam owner_t             RST_OWNER = (HOST_FIRST != 0) ? OWN_HOST : OWN_CORE;

    owner_t             last_owner_r;
    owner_t             owner_next_s;
    owner_t             gnt_side_s;
    logic [BURST_W-1:0] burst_cnt_r;
    logic [BURST_W-1:0] burst_next_s;
    lock_t              lock_state_r;
    lock_t              lock_next_s;
    logic               core_win_s;
    logic               host_win_s;
    logic               gnt_any_s;
    logic               other_req_s;
    logic               rd_gnt_s;
    logic               rd_pend_r;
    owner_t             rd_tag_r;
    logic [DATA_W-1:0]  core_rdata_r;
    logic [DATA_W-1:0]  host_rdata_r;

    arb_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .core_req   (core_req),
        .host_req   (host_req),
        .last_owner (last_owner_r),
        .burst_cnt  (burst_cnt_r),
        .lock_state (lock_state_r),
        .core_win   (core_win_s),
        .host_win   (host_win_s)
    );

    // Grants are qualified by rst_n so every output is low while reset is held.
    assign core_gnt    = core_win_s & rst_n;
    assign host_gnt    = host_win_s & rst_n;
    assign gnt_any_s   = core_win_s | host_win_s;
    assign gnt_side_s  = host_win_s ? OWN_HOST : OWN_CORE;
    assign other_req_s = host_win_s ? core_req : host_req;
    assign rd_gnt_s    = (core_win_s & ~core_we) | (host_win_s & ~host_we);

    assign core_rvalid = rd_pend_r & (rd_tag_r == OWN_CORE);
    assign host_rvalid = rd_pend_r & (rd_tag_r == OWN_HOST);
    assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_r;
    assign host_rdata  = host_rvalid ? mem_rdata : host_rdata_r;

    // RAM command mux from whichever side holds the grant.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (core_gnt) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (host_gnt) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else begin
            mem_en    = 1'b0;
        end
    end

    // Ownership and burst length bookkeeping; uncontested grants clear the burst.
    always_comb begin
        owner_next_s = last_owner_r;
        burst_next_s = burst_cnt_r;
        if (gnt_any_s) begin
            owner_next_s = gnt_side_s;
            if (!other_req_s) begin
                burst_next_s = {BURST_W{1'b0}};
            end else if (gnt_side_s != last_owner_r) begin
                burst_next_s = {{(BURST_W-1){1'b0}}, 1'b1};
            end else begin
                burst_next_s = burst_sat_inc(burst_cnt_r, MAX_B);
            end
        end else begin
            owner_next_s = last_owner_r;
        end
    end

    // Lock FSM next state: a locked host grant closes the port to the core.
    always_comb begin
        lock_next_s = lock_state_r;
        case (lock_state_r)
            UNLOCKED: begin
                if (host_win_s && host_lock) begin
                    lock_next_s = LOCKED;
                end else begin
                    lock_next_s = UNLOCKED;
                end
            end
            LOCKED: begin
                if (!host_lock) begin
                    lock_next_s = UNLOCKED;
                end else begin
                    lock_next_s = LOCKED;
                end
            end
            default: lock_next_s = UNLOCKED;
        endcase
    end

    // Arbitration state, lock state and the 1-cycle read return tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_r <= RST_OWNER;
            burst_cnt_r  <= {BURST_W{1'b0}};
            lock_state_r <= UNLOCKED;
            rd_pend_r    <= 1'b0;
            rd_tag_r     <= OWN_CORE;
        end else begin
            last_owner_r <= owner_next_s;
            burst_cnt_r  <= burst_next_s;
            lock_state_r <= lock_next_s;
            rd_pend_r    <= rd_gnt_s;
            rd_tag_r     <= gnt_side_s;
        end
    end

    // Each side keeps its last returned read data between returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rdata_r <= {DATA_W{1'b0}};
            host_rdata_r <= {DATA_W{1'b0}};
        end else begin
            if (core_rvalid) begin
                core_rdata_r <= mem_rdata;
            end
            if (host_rvalid) begin
                host_rdata_r <= mem_rdata;
            end
        end
    end

`ifdef ARB_STALL_STATS_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles the core waits on an ungranted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'h0000;
        end else if (stats_clr) begin
            stall_cnt_r <= 16'h0000;
        end else if (core_req && !core_win_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign core_stall_cnt = stall_cnt_r;
`endif

endmodule
